mb_rx: RTL
==========

Name: mb_rx

Overview:
Mainband receiver for the 16-lane UCIe logphy data path. It is the receive-side counterpart of the mainband transmitter. It samples the valid pin and the 16 data pins once per UI and checks the valid framing. It deserializes four 16-byte fragments into one 64-byte flit, buffers completed flits in a small FIFO, and hands them to the adapter over a valid/ready handshake.

Parameters:
flit_buffer_size, 2, FIFO depth in flits; power of 2, >= 2.
err_cnt_width, 8, width of the saturating error and drop counters.

Ports:
clk  input  1  UI-rate sampling clock; one bit per lane is sampled per posedge.
reset  input  1  synchronous, active-low reset; reset==0 at a posedge resets the block.
valid_pin_i  input  1  received mainband valid pin.
dataPins_i  input  16  received mainband data lanes.
data_o  output  8x64  head flit of the FIFO, as data_o[63:0] of 8 bits each.
flit_valid_o  output  1  FIFO non-empty; data_o is valid.
flit_ready_i  input  1  consumer accepts the head flit when asserted together with flit_valid_o.
receiving_o  output  1  a flit is in progress (state RECV).
frame_err_o  output  1  one-cycle pulse on a valid-framing violation.
overflow_o  output  1  one-cycle pulse when a completed flit is dropped because the FIFO is full.
err_cnt_o  output  err_cnt_width  saturating count of frame_err_o pulses.
drop_cnt_o  output  err_cnt_width  saturating count of overflow_o pulses.

Behaviour:
- Wire format:
  - A flit is 4 fragments x 8 UIs (32 UIs).
  - In fragment f, lane k carries byte f*16+k, LSB first: bit n at UI n.
  - valid_pin_i is 1 for UIs 0-3 and 0 for UIs 4-7 of every fragment.
  - Fragments and flits are sent back-to-back with no gap.
- Reset (reset==0 at a posedge):
  - State is IDLE; ui_ctr=0; frag_idx=0.
  - FIFO is emptied (read/write pointers 0, count 0); shift registers are cleared.
  - All outputs are 0, including data_o (the empty head entry is 0).
  - Reset mid-flit discards the partial flit without raising frame_err_o.
- IDLE:
  - valid_pin_i==1 is treated as UI0 of fragment 0. The data bits are captured as bit 0, ui_ctr becomes 1, and the state goes to RECV.
  - valid_pin_i==0 keeps the block in IDLE, with data ignored.
- RECV:
  - Each posedge captures dataPins_i[k] into bit ui_ctr of byte frag_idx*16+k, then increments ui_ctr (3-bit, wraps 7->0).
  - When ui_ctr wraps from 7, frag_idx increments (2-bit).
- Framing check in RECV:
  - Expected valid is (ui_ctr<4).
  - A mismatch at any UI pulses frame_err_o, increments err_cnt_o, discards the partial flit, and returns to IDLE.
  - If the erroneous sample has valid_pin_i==1, it is not re-used as a new UI0.
- Flit completion at UI7 of fragment 3:
  - The assembled 64 bytes, including the current sample, are pushed into the FIFO in the same posedge.
  - The state returns to IDLE with ui_ctr=0 and frag_idx=0.
  - The next UI with valid high starts a new flit immediately; back-to-back flits lose no UI.
- Latency: flit_valid_o rises in the cycle right after the posedge that samples UI31, when the FIFO was empty.
- FIFO:
  - Pop occurs when flit_valid_o && flit_ready_i at a posedge.
  - A push while count==flit_buffer_size is dropped unless a pop occurs in the same cycle; a simultaneous pop makes room and the push is accepted.
  - A dropped push pulses overflow_o and increments drop_cnt_o.
  - Push and pop on the same cycle leave count unchanged.
  - Pointers wrap modulo flit_buffer_size.
- Counters saturate at all-ones and never wrap.
- frame_err_o and overflow_o are registered, asserted for exactly one cycle after the event posedge.
- receiving_o is 1 exactly while the state is RECV.

Test Plan:
- Single flit, byte j = j (0x00..0x3F), ready=1 -> flit_valid_o high 1 cycle after UI31; data_o[j]==j for all j; one-cycle valid; no errors.
- Three back-to-back flits A/B/C, depth 2, ready=0 -> A and B buffered; C dropped; overflow_o pulses once; drop_cnt_o==1. Then ready=1 -> A popped, then B; flit_valid_o falls after B.
- valid_pin_i forced 0 at UI2 of fragment 1 -> frame_err_o pulses once; err_cnt_o==1; no flit pushed. A following good flit with bytes 0xFF-j is received correctly.
- valid_pin_i held 1 at UI4 of fragment 0 -> frame_err_o pulses; state IDLE; receiving_o==0.
- FIFO full (2 flits), with ready=1 on the same cycle a third flit completes -> push accepted, overflow_o stays 0, count stays 2, order A,B,C preserved.
- reset==0 at UI17 of a flit -> all outputs 0 next cycle; a subsequent full flit is received intact. Separately, 300 framing errors -> err_cnt_o==255 (saturated).

Source files
------------

// File: rtl/mb_rx.sv
// mb_rx - UCIe mainband receiver, 16-lane logphy data path.
//
// Samples the valid pin and 16 data lanes once per UI, checks the valid
// framing (1 for UIs 0-3, 0 for UIs 4-7 of each 8-UI fragment), deserializes
// four fragments into a 64-byte flit and queues finished flits in a small FIFO.
//
// Ports:
//   clk           UI-rate sampling clock
//   reset         synchronous, active-low
//   valid_pin_i   received mainband valid pin
//   dataPins_i    received data lanes; lane k of fragment f carries byte f*16+k, LSB first
//   data_o        head flit of the FIFO (64 bytes), all zero while the FIFO is empty
//   flit_valid_o  FIFO non-empty
//   flit_ready_i  consumer accepts the head flit
//   receiving_o   a flit is in progress (FSM state RECV); this is the FSM state view
//   frame_err_o   one-cycle pulse after a framing violation
//   overflow_o    one-cycle pulse after a completed flit was dropped (FIFO full)
//   err_cnt_o     saturating count of frame_err_o pulses
//   drop_cnt_o    saturating count of overflow_o pulses
//
// Handshake: the head flit transfers at a posedge where flit_valid_o and
// flit_ready_i are both high. flit_valid_o never depends on flit_ready_i, and
// data_o stays stable while flit_valid_o is high and the flit is not taken.

module mb_rx #(
  parameter int flit_buffer_size = 2,
  parameter int err_cnt_width    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_pin_i,
  input  logic [15:0]              dataPins_i,
  output logic [63:0][7:0]         data_o,
  output logic                     flit_valid_o,
  input  logic                     flit_ready_i,
  output logic                     receiving_o,
  output logic                     frame_err_o,
  output logic                     overflow_o,
  output logic [err_cnt_width-1:0] err_cnt_o,
  output logic [err_cnt_width-1:0] drop_cnt_o
);

  localparam int PTR_W = $clog2(flit_buffer_size);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_RECV = 1'b1} state_e;

  state_e                   state_q, state_d;
  logic [2:0]               ui_ctr_q, ui_ctr_d;
  logic [1:0]               frag_idx_q, frag_idx_d;
  logic [63:0][7:0]         asm_q, asm_d;
  logic [63:0][7:0]         mem_q [flit_buffer_size];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     frame_err_q, frame_err_d;
  logic                     overflow_q, overflow_d;
  logic [err_cnt_width-1:0] err_cnt_q, err_cnt_d, drop_cnt_q, drop_cnt_d;

  logic       capture, push, pop, full, push_ok;
  logic [2:0] cap_ui;
  logic [1:0] cap_frag;

  // State register (plus datapath flops)
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ui_ctr_q    <= '0;
      frag_idx_q  <= '0;
      asm_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      err_cnt_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ui_ctr_q    <= ui_ctr_d;
      frag_idx_q  <= frag_idx_d;
      asm_q       <= asm_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      err_cnt_q   <= err_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // FIFO storage is not reset; the empty head reads as zero through data_o.
  always_ff @(posedge clk) begin
    if (reset && push_ok) mem_q[wr_ptr_q] <= asm_d;
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    ui_ctr_d    = ui_ctr_q;
    frag_idx_d  = frag_idx_q;
    capture     = 1'b0;
    push        = 1'b0;
    frame_err_d = 1'b0;
    cap_ui      = ui_ctr_q;
    cap_frag    = frag_idx_q;
    case (state_q)
      ST_IDLE: begin
        // A high valid in IDLE is UI0 of fragment 0.
        if (valid_pin_i) begin
          capture    = 1'b1;
          cap_ui     = 3'd0;
          cap_frag   = 2'd0;
          ui_ctr_d   = 3'd1;
          frag_idx_d = 2'd0;
          state_d    = ST_RECV;
        end
      end
      ST_RECV: begin
        if (valid_pin_i != (ui_ctr_q < 3'd4)) begin
          // Bad framing: drop the partial flit; this sample never starts a new one.
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
          ui_ctr_d    = 3'd0;
          frag_idx_d  = 2'd0;
        end else begin
          capture = 1'b1;
          if (ui_ctr_q == 3'd7 && frag_idx_q == 2'd3) begin
            push       = 1'b1;
            state_d    = ST_IDLE;
            ui_ctr_d   = 3'd0;
            frag_idx_d = 2'd0;
          end else begin
            ui_ctr_d = ui_ctr_q + 3'd1;
            if (ui_ctr_q == 3'd7) frag_idx_d = frag_idx_q + 2'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Deserializer: the pushed flit is asm_d so it already holds the UI31 sample.
  always_comb begin
    asm_d = asm_q;
    if (capture) begin
      for (int k = 0; k < 16; k++) begin
        asm_d[{cap_frag, 4'(k)}][cap_ui] = dataPins_i[k];
      end
    end
  end

  // FIFO and counters
  always_comb begin
    pop     = (count_q != '0) && flit_ready_i;
    full    = (count_q == CNT_W'(flit_buffer_size));
    // A pop in the same cycle frees the slot the push needs.
    push_ok = push && (!full || pop);
    overflow_d = push && full && !pop;
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop) count_d = count_q + CNT_W'(1);
    else if (pop && !push_ok) count_d = count_q - CNT_W'(1);
    err_cnt_d  = (frame_err_d && err_cnt_q != '1) ? err_cnt_q + 1'b1 : err_cnt_q;
    drop_cnt_d = (overflow_d && drop_cnt_q != '1) ? drop_cnt_q + 1'b1 : drop_cnt_q;
  end

  // Output logic
  always_comb begin
    receiving_o  = (state_q == ST_RECV);
    flit_valid_o = (count_q != '0);
    data_o       = flit_valid_o ? mem_q[rd_ptr_q] : '0;
    frame_err_o  = frame_err_q;
    overflow_o   = overflow_q;
    err_cnt_o    = err_cnt_q;
    drop_cnt_o   = drop_cnt_q;
  end

endmodule
